// File: rtl/vision_pkg.sv
// -----------------------------------------------------------------------------
// vision_pkg
//   Definitions shared by the vision pipeline blocks (edge_conv, edge_threshold):
//   channel width, channel slice positions inside a 30-bit RGB word, the packed
//   pixel struct and the default frame geometry.
// -----------------------------------------------------------------------------
package vision_pkg;

    localparam int CH_W  = 10;          // bits per colour channel
    localparam int ABS_W = CH_W - 1;    // |signed channel| after saturation
    localparam int MAG_W = ABS_W + 2;   // sum of three ABS_W values

    // Channel slices within a packed pixel word
    localparam int R_HI = 3 * CH_W - 1;
    localparam int R_LO = 2 * CH_W;
    localparam int G_HI = 2 * CH_W - 1;
    localparam int G_LO = CH_W;
    localparam int B_HI = CH_W - 1;
    localparam int B_LO = 0;

    // Default frame geometry
    localparam int DEF_WIDTH  = 320;
    localparam int DEF_HEIGHT = 240;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pixel_t;

endpackage

// File: rtl/edge_threshold_abs_sat.sv
// -----------------------------------------------------------------------------
// abs_sat
//   Absolute value of a signed CH_W-bit channel, saturated to ABS_W unsigned
//   bits. Only the most negative input (-512) overflows; it maps to 511.
//   Purely combinational.
//
// Ports
//   c : signed CH_W-bit channel value
//   a : unsigned ABS_W-bit saturated magnitude
// -----------------------------------------------------------------------------
module abs_sat
    import vision_pkg::*;
(
    input  logic signed [CH_W-1:0]  c,
    output logic        [ABS_W-1:0] a
);

    localparam logic signed [CH_W-1:0] MOST_NEG = {1'b1, {(CH_W-1){1'b0}}};

    logic signed [CH_W-1:0] neg;

    always_comb begin
        neg = -c;
        if (c == MOST_NEG) begin
            a = '1;
        end else if (c[CH_W-1]) begin
            a = neg[ABS_W-1:0];
        end else begin
            a = c[ABS_W-1:0];
        end
    end

endmodule

// File: rtl/edge_threshold.sv
// -----------------------------------------------------------------------------
// edge_threshold
//   Consumes the signed per-channel edge-convolution result, forms the gradient
//   magnitude |R|+|G|+|B|, compares it against a runtime threshold, masks the
//   two leading border rows/columns and emits either a binary edge map or a
//   saturated grey magnitude image. Also reports the number of edge pixels in
//   the last completed frame.
//
//   Two-stage pipeline with full backpressure:
//     stage 1 (_p1): magnitude, border flag, frame-end flag, thresh and mode
//     stage 2 (_p2): output pixel register driving y_data
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   x_data/valid/ready  : input stream, three signed 10-bit channels
//   y_data/valid/ready  : output stream, three unsigned 10-bit channels
//   thresh              : edge threshold, captured with each pixel
//   mode                : 0 = binary edge map, 1 = magnitude image
//   edge_count          : edge pixels counted in the last completed frame
//   frame_done          : one-cycle pulse when edge_count updates
// -----------------------------------------------------------------------------
module edge_threshold
    import vision_pkg::*;
#(
    parameter int W        = 30,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int THRESH_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [W-1:0]        x_data,
    input  logic                x_valid,
    output logic                x_ready,

    output logic [W-1:0]        y_data,
    output logic                y_valid,
    input  logic                y_ready,

    input  logic [THRESH_W-1:0] thresh,
    input  logic                mode,

    output logic [16:0]         edge_count,
    output logic                frame_done
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CNT_W = 17;

    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [THRESH_W-1:0] CH_MAX   = THRESH_W'((1 << CH_W) - 1);

    // Sum of three saturated channel magnitudes, zero-extended to THRESH_W
    function automatic logic [THRESH_W-1:0] mag_sum(
        input logic [ABS_W-1:0] a0,
        input logic [ABS_W-1:0] a1,
        input logic [ABS_W-1:0] a2
    );
        logic [MAG_W-1:0] s;
        s = {2'b00, a0} + {2'b00, a1} + {2'b00, a2};
        return THRESH_W'(s);
    endfunction

    // Clamp a magnitude into one output channel
    function automatic logic [CH_W-1:0] sat_ch(input logic [THRESH_W-1:0] m);
        if (m > CH_MAX) begin
            return '1;
        end
        return m[CH_W-1:0];
    endfunction

    // Handshake / enables
    logic en1, en2, accept, adv2;
    logic vld_p1, vld_p2;

    assign en2     = !vld_p2 || y_ready;
    assign en1     = !vld_p1 || en2;
    assign x_ready = en1;
    assign accept  = x_valid && x_ready;
    assign adv2    = vld_p1 && en2;

    // Pixel position of the incoming beat
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Input unpack and per-channel magnitude
    pixel_t           px_in;
    logic [ABS_W-1:0] abs_r, abs_g, abs_b;
    logic             border_in, last_in;

    assign px_in = x_data;

    abs_sat u_abs_r (.c(px_in.r), .a(abs_r));
    abs_sat u_abs_g (.c(px_in.g), .a(abs_g));
    abs_sat u_abs_b (.c(px_in.b), .a(abs_b));

    // The first two columns/rows hold a 3x3 window that is not yet full or
    // that wraps across a line edge.
    assign border_in = (col < COL_W'(2)) || (row < ROW_W'(2));
    assign last_in   = (col == COL_LAST) && (row == ROW_LAST);

    // ---- stage 1 ----
    logic [THRESH_W-1:0] mag_p1;
    logic [THRESH_W-1:0] thresh_p1;
    logic                mode_p1;
    logic                border_p1;
    logic                last_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (en1) begin
            vld_p1 <= x_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mag_p1    <= mag_sum(abs_r, abs_g, abs_b);
            thresh_p1 <= thresh;
            mode_p1   <= mode;
            border_p1 <= border_in;
            last_p1   <= last_in;
        end
    end

    // Output pixel selection for the stage-1 pixel
    logic   edge_p1, hit_p1;
    pixel_t pix_nxt;

    assign edge_p1 = (mag_p1 >= thresh_p1);
    assign hit_p1  = edge_p1 && !border_p1;

    always_comb begin
        pix_nxt = '0;
        if (!border_p1) begin
            if (mode_p1) begin
                pix_nxt.r = sat_ch(mag_p1);
                pix_nxt.g = sat_ch(mag_p1);
                pix_nxt.b = sat_ch(mag_p1);
            end else if (edge_p1) begin
                pix_nxt = '1;
            end
        end
    end

    // ---- stage 2 ----
    pixel_t pix_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            pix_p2 <= '0;
        end else if (en2) begin
            vld_p2 <= vld_p1;
            pix_p2 <= pix_nxt;
        end
    end

    assign y_data  = pix_p2;
    assign y_valid = vld_p2;

    // Edge accumulator: counted as each pixel moves into the output register,
    // so the frame-end pixel's own contribution lands in the published total.
    logic [CNT_W-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            edge_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (adv2) begin
                if (last_p1) begin
                    edge_count <= acc + CNT_W'(hit_p1);
                    acc        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    acc <= acc + CNT_W'(hit_p1);
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_threshold.sv
module tb_edge_threshold;

    localparam int WD   = 20;
    localparam int HT   = 20;
    localparam int NPIX = WD * HT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [29:0] x_data = '0;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic [29:0] y_data;
    logic        y_valid;
    logic        y_ready = 1'b1;
    logic [11:0] thresh = '0;
    logic        mode = 1'b0;
    logic [16:0] edge_count;
    logic        frame_done;

    always #5 clk = ~clk;

    edge_threshold #(
        .W(30), .WIDTH(WD), .HEIGHT(HT), .THRESH_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
        .thresh(thresh), .mode(mode),
        .edge_count(edge_count), .frame_done(frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [29:0] exp_pix_q[$];
    int          exp_cnt_q[$];

    int m_idx = 0;       // model pixel index within the frame
    int m_acc = 0;       // model edge count for the current frame
    int frames_exp = 0;
    int pulses = 0;
    bit rand_rdy = 0;
    bit bubbles = 0;
    int stall_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: per-pixel result from position, input word, threshold, mode
    function automatic logic [29:0] ref_pix(input int col, input int row,
                                            input logic [29:0] d, input int thr,
                                            input bit md, output bit hit);
        int m;
        int v;
        int a;
        logic [9:0] chv;
        m = 0;
        for (int k = 0; k < 3; k++) begin
            chv = d[k*10 +: 10];
            v = int'($signed(chv));
            a = (v < 0) ? -v : v;
            if (a > 511) a = 511;
            m += a;
        end
        hit = 1'b0;
        if (col < 2 || row < 2) return 30'd0;
        hit = (m >= thr);
        if (!md) return hit ? {30{1'b1}} : 30'd0;
        if (m > 1023) m = 1023;
        return {3{10'(m)}};
    endfunction

    task automatic send(input logic [29:0] d, input int thr, input bit md);
        bit hit;
        int waited;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bubbles && ($urandom % 2 == 1)) begin
                x_valid = 1'b0;
            end else begin
                x_valid = 1'b1;
                x_data  = d;
                thresh  = 12'(thr);
                mode    = md;
            end
            #2;
            if (x_valid && x_ready) break;
            waited++;
            if (waited > 1000) begin
                $display("FAIL send_timeout: x_ready stuck, got %0d expected 1", x_ready);
                $fatal(1, "input stream blocked");
            end
        end
        exp_pix_q.push_back(ref_pix(m_idx % WD, m_idx / WD, d, thr, md, hit));
        m_acc += int'(hit);
        m_idx++;
        if (m_idx == NPIX) begin
            exp_cnt_q.push_back(m_acc);
            m_acc = 0;
            m_idx = 0;
            frames_exp++;
        end
    endtask

    task automatic send_rand();
        send(30'($urandom), $urandom_range(0, 1600), 1'($urandom % 2));
    endtask

    // Output-side ready generator, with a forced stall window
    initial begin
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                y_ready = 1'b0;
                stall_cnt--;
                #3;
                if (x_valid) check("stall_x_ready", x_ready, 0);
            end else begin
                y_ready = rand_rdy ? 1'($urandom % 2) : 1'b1;
            end
        end
    end

    // Monitor: compares every output transfer and every frame_done pulse
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (y_valid && y_ready) begin
                    if (exp_pix_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out: got 0x%0h, expected no output", y_data);
                    end else begin
                        check("y_data", y_data, exp_pix_q.pop_front());
                    end
                end
                if (frame_done) begin
                    pulses++;
                    if (exp_cnt_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame_done: edge_count %0d, expected no pulse", edge_count);
                    end else begin
                        check("edge_count", edge_count, exp_cnt_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int t;
        #1 rst_n = 1'b0;
        #1;
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_edge_count", edge_count, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_x_ready", x_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Uniform +100 frame, binary map: interior all edges
        for (int i = 0; i < NPIX; i++) send({3{10'd100}}, 200, 1'b0);

        // Directed corner cases mixed into a random frame, plus a stall
        for (int i = 0; i < NPIX; i++) begin
            case (i)
                105:     send({10'h200, 10'h3FF, 10'h000}, 0, 1'b1);
                106:     send({10'd100, 10'd100, 10'd99}, 300, 1'b0);
                107:     send({10'd100, 10'd100, 10'd100}, 300, 1'b0);
                default: send_rand();
            endcase
            if (i == 200) stall_cnt = 5;
        end

        // Three random frames with bubbles and backpressure
        bubbles  = 1;
        rand_rdy = 1;
        for (int i = 0; i < 3 * NPIX; i++) send_rand();

        // Reset in the middle of a frame
        for (int i = 0; i < 37; i++) send_rand();
        @(negedge clk);
        x_valid = 1'b0;
        check("pulses_before_reset", pulses, frames_exp);
        rst_n = 1'b0;
        #1;
        check("midrst_y_valid", y_valid, 0);
        check("midrst_y_data", y_data, 0);
        check("midrst_edge_count", edge_count, 0);
        check("midrst_frame_done", frame_done, 0);
        exp_pix_q.delete();
        exp_cnt_q.delete();
        m_idx = 0;
        m_acc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Frame after reset must restart at (0,0)
        for (int i = 0; i < NPIX; i++) send({3{10'd100}}, 200, 1'b0);

        t = 0;
        while ((exp_pix_q.size() > 0 || exp_cnt_q.size() > 0) && t < 2000) begin
            @(negedge clk);
            x_valid = 1'b0;
            t++;
        end
        if (exp_pix_q.size() > 0 || exp_cnt_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d pixels and %0d counts outstanding, expected 0",
                     exp_pix_q.size(), exp_cnt_q.size());
        end
        repeat (4) @(negedge clk);
        check("frame_done_pulses", pulses, frames_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
